// File: rtl/configurable_gate_array.sv
// Array of independent, runtime-configurable logic gates with a per-channel
// propagation delay. The delay is either a transport delay (a shift register
// that passes any pulse) or an inertial delay (a counter that rejects short
// pulses). Each channel also flags every change of its output for one cycle.
module configurable_gate_array #(
    parameter int unsigned GATES        = 4,
    parameter int unsigned INPUTS       = 2,
    parameter int unsigned DELAY_CYCLES = 1,
    parameter int unsigned INERTIAL     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [2:0]                func,
    input  logic [GATES*INPUTS-1:0]   a,
    output logic [GATES-1:0]          y,
    output logic [GATES-1:0]          chg
);

    localparam int unsigned CW = $clog2(DELAY_CYCLES + 1);

    // Evaluate one gate on its input slice for the selected function code.
    function automatic logic gate_eval(input logic [2:0] f, input logic [INPUTS-1:0] v);
        logic o;
        case (f)
            3'b000:  o = &v;
            3'b001:  o = |v;
            3'b010:  o = ~&v;
            3'b011:  o = ~|v;
            3'b100:  o = ^v;
            3'b101:  o = ~^v;
            3'b110:  o = v[0];
            default: o = ~v[0];
        endcase
        return o;
    endfunction

    logic [GATES-1:0] r;

    // Raw, undelayed gate results for every channel.
    always_comb begin
        r = '0;
        for (int g = 0; g < GATES; g++) begin
            r[g] = gate_eval(func, a[g*INPUTS +: INPUTS]);
        end
    end

    for (genvar g = 0; g < GATES; g++) begin : g_chan
        logic y_q;
        logic chg_q;

        if (INERTIAL == 0) begin : g_transport
            logic [DELAY_CYCLES-1:0] pipe_q;
            logic [DELAY_CYCLES-1:0] pipe_d;

            // Next pipeline contents: shift up by one, newest sample in stage 0.
            always_comb begin
                pipe_d    = pipe_q << 1;
                pipe_d[0] = r[g];
            end

            // Advance the delay line on enabled edges; flag a change of its last stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_q <= '0;
                    chg_q  <= 1'b0;
                end else begin
                    chg_q <= en && (pipe_d[DELAY_CYCLES-1] != pipe_q[DELAY_CYCLES-1]);
                    if (en) begin
                        pipe_q <= pipe_d;
                    end
                end
            end

            assign y_q = pipe_q[DELAY_CYCLES-1];
        end else begin : g_inertial
            localparam logic [CW-1:0] Target = CW'(DELAY_CYCLES);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_inc;
            logic          out_q;

            assign cnt_inc = cnt_q + 1'b1;

            // Count consecutive enabled edges where the result disagrees with the
            // output; commit only once the disagreement has lasted the full delay.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    out_q <= 1'b0;
                    chg_q <= 1'b0;
                end else begin
                    chg_q <= 1'b0;
                    if (en) begin
                        if (r[g] == out_q) begin
                            cnt_q <= '0;
                        end else if (cnt_inc == Target) begin
                            out_q <= r[g];
                            cnt_q <= '0;
                            chg_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
            end

            assign y_q = out_q;
        end

        assign y[g]   = y_q;
        assign chg[g] = chg_q;
    end

endmodule

// File: tb/tb_configurable_gate_array.sv
// Directed testbench for configurable_gate_array: a function table on a
// transport instance plus hand-written multi-cycle sequences for delay,
// glitch rejection, enable gating, function switching and reset.
module tb_configurable_gate_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  func;
    logic [7:0]  a_tr3, a_in3, a_tr2;
    logic [11:0] a_par;
    logic [3:0]  y_tr3, chg_tr3, y_in3, chg_in3, y_tr2, chg_tr2, y_par, chg_par;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    configurable_gate_array #(.GATES(4), .INPUTS(2), .DELAY_CYCLES(3), .INERTIAL(0)) u_tr3 (
        .clk(clk), .rst_n(rst_n), .en(en), .func(func), .a(a_tr3), .y(y_tr3), .chg(chg_tr3)
    );
    configurable_gate_array #(.GATES(4), .INPUTS(2), .DELAY_CYCLES(3), .INERTIAL(1)) u_in3 (
        .clk(clk), .rst_n(rst_n), .en(en), .func(func), .a(a_in3), .y(y_in3), .chg(chg_in3)
    );
    configurable_gate_array #(.GATES(4), .INPUTS(2), .DELAY_CYCLES(2), .INERTIAL(0)) u_tr2 (
        .clk(clk), .rst_n(rst_n), .en(en), .func(func), .a(a_tr2), .y(y_tr2), .chg(chg_tr2)
    );
    configurable_gate_array #(.GATES(4), .INPUTS(3), .DELAY_CYCLES(2), .INERTIAL(0)) u_par (
        .clk(clk), .rst_n(rst_n), .en(en), .func(func), .a(a_par), .y(y_par), .chg(chg_par)
    );

    typedef struct {
        logic [2:0] f;
        logic [7:0] a;
        logic [3:0] y;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Gate g sees a[2g+1:2g]; 8'b11_10_01_00 gives gates inputs 00,01,10,11.
        tbl[0]  = '{3'b000, 8'b11100100, 4'b1000};
        tbl[1]  = '{3'b001, 8'b11100100, 4'b1110};
        tbl[2]  = '{3'b010, 8'b11100100, 4'b0111};
        tbl[3]  = '{3'b011, 8'b11100100, 4'b0001};
        tbl[4]  = '{3'b100, 8'b11100100, 4'b0110};
        tbl[5]  = '{3'b101, 8'b11100100, 4'b1001};
        tbl[6]  = '{3'b110, 8'b11100100, 4'b1010};
        tbl[7]  = '{3'b111, 8'b11100100, 4'b0101};
        tbl[8]  = '{3'b000, 8'b11111111, 4'b1111};
        tbl[9]  = '{3'b011, 8'b00000000, 4'b1111};
        tbl[10] = '{3'b100, 8'b01101100, 4'b1100};

        rst_n = 1'b0;
        en    = 1'b1;
        func  = 3'b011;
        a_tr3 = '0;
        a_in3 = '0;
        a_tr2 = '0;
        a_par = '0;

        // Reset state, checked before any clock edge.
        #2;
        check("reset_y_tr3", y_tr3, 4'b0000);
        check("reset_chg_tr3", chg_tr3, 4'b0000);
        check("reset_y_in3", y_in3, 4'b0000);
        check("reset_y_par", y_par, 4'b0000);

        // NOR of all-zero inputs: y climbs from reset 0 to 1 after three edges.
        tick();
        rst_n = 1'b1;
        tick();
        check("nor_e1_y", y_tr3, 4'b0000);
        check("nor_e1_chg", chg_tr3, 4'b0000);
        tick();
        check("nor_e2_y", y_tr3, 4'b0000);
        check("nor_e2_y_inert", y_in3, 4'b0000);
        tick();
        check("nor_e3_y", y_tr3, 4'b1111);
        check("nor_e3_chg", chg_tr3, 4'b1111);
        check("nor_e3_y_inert", y_in3, 4'b1111);
        check("nor_e3_chg_inert", chg_in3, 4'b1111);
        tick();
        check("nor_e4_y", y_tr3, 4'b1111);
        check("nor_e4_chg", chg_tr3, 4'b0000);

        // Function table: hold each vector long enough to fill the pipeline.
        for (int i = 0; i < 11; i++) begin
            func  = tbl[i].f;
            a_tr3 = tbl[i].a;
            repeat (3) tick();
            check($sformatf("table_%0d_func%b", i, tbl[i].f), y_tr3, tbl[i].y);
        end

        // Transport passes a one-cycle pulse on gate 0 only.
        do_reset();
        func  = 3'b001;
        a_tr3 = '0;
        repeat (4) tick();
        check("pulse_pre_y", y_tr3, 4'b0000);
        a_tr3 = 8'h01;
        tick();
        a_tr3 = '0;
        check("pulse_e1_y", y_tr3, 4'b0000);
        tick();
        check("pulse_e2_y", y_tr3, 4'b0000);
        tick();
        check("pulse_e3_y", y_tr3, 4'b0001);
        check("pulse_e3_chg", chg_tr3, 4'b0001);
        tick();
        check("pulse_e4_y", y_tr3, 4'b0000);
        check("pulse_e4_chg", chg_tr3, 4'b0001);
        tick();
        check("pulse_e5_chg", chg_tr3, 4'b0000);

        // Inertial: a two-edge pulse is rejected, a three-edge pulse passes.
        do_reset();
        func  = 3'b110;
        a_in3 = '0;
        repeat (2) tick();
        a_in3 = 8'h01;
        tick();
        check("inert_short_e1_y", y_in3, 4'b0000);
        tick();
        check("inert_short_e2_y", y_in3, 4'b0000);
        a_in3 = '0;
        tick();
        check("inert_short_e3_y", y_in3, 4'b0000);
        check("inert_short_e3_chg", chg_in3, 4'b0000);
        tick();
        check("inert_short_e4_y", y_in3, 4'b0000);
        a_in3 = 8'h01;
        tick();
        check("inert_long_e1_y", y_in3, 4'b0000);
        tick();
        check("inert_long_e2_y", y_in3, 4'b0000);
        check("inert_long_e2_chg", chg_in3, 4'b0000);
        tick();
        check("inert_long_e3_y", y_in3, 4'b0001);
        check("inert_long_e3_chg", chg_in3, 4'b0001);
        tick();
        check("inert_long_e4_y", y_in3, 4'b0001);
        check("inert_long_e4_chg", chg_in3, 4'b0000);

        // Enable gating on the two-deep transport instance.
        do_reset();
        func  = 3'b110;
        a_tr2 = '0;
        repeat (3) tick();
        a_tr2 = 8'h55;
        tick();
        check("en_e1_y", y_tr2, 4'b0000);
        en = 1'b0;
        tick();
        check("en_off1_y", y_tr2, 4'b0000);
        check("en_off1_chg", chg_tr2, 4'b0000);
        tick();
        check("en_off2_y", y_tr2, 4'b0000);
        en = 1'b1;
        tick();
        check("en_e2_y", y_tr2, 4'b1111);
        check("en_e2_chg", chg_tr2, 4'b1111);
        tick();
        check("en_e3_chg", chg_tr2, 4'b0000);
        en    = 1'b0;
        a_tr2 = '0;
        tick();
        check("en_hold_y", y_tr2, 4'b1111);
        check("en_hold_chg", chg_tr2, 4'b0000);
        en = 1'b1;

        // Function switch mid-stream, then reset with a loaded pipeline.
        do_reset();
        func  = 3'b000;
        a_tr3 = 8'hFF;
        repeat (5) tick();
        check("sw_steady_y", y_tr3, 4'b1111);
        func = 3'b010;
        tick();
        check("sw_e1_y", y_tr3, 4'b1111);
        check("sw_e1_chg", chg_tr3, 4'b0000);
        tick();
        check("sw_e2_y", y_tr3, 4'b1111);
        tick();
        check("sw_e3_y", y_tr3, 4'b0000);
        check("sw_e3_chg", chg_tr3, 4'b1111);
        func = 3'b000;
        repeat (3) tick();
        check("sw_back_y", y_tr3, 4'b1111);
        check("sw_back_chg", chg_tr3, 4'b1111);
        rst_n = 1'b0;
        #1;
        check("async_rst_y", y_tr3, 4'b0000);
        check("async_rst_chg", chg_tr3, 4'b0000);
        func = 3'b010;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("discard_e%0d_y", i + 1), y_tr3, 4'b0000);
        end
        func = 3'b000;
        tick();
        check("recover_e1_y", y_tr3, 4'b0000);
        tick();
        check("recover_e2_y", y_tr3, 4'b0000);
        tick();
        check("recover_e3_y", y_tr3, 4'b1111);
        check("recover_e3_chg", chg_tr3, 4'b1111);

        // Three-input parity sweep: gate g gets code (c+g) mod 8.
        do_reset();
        func = 3'b100;
        for (int c = 0; c < 8; c++) begin
            logic [11:0] av;
            logic [3:0]  ey;
            logic [2:0]  cg;
            av = '0;
            ey = '0;
            for (int g = 0; g < 4; g++) begin
                cg             = 3'((c + g) % 8);
                av[g*3 +: 3]   = cg;
                ey[g]          = ^cg;
            end
            a_par = av;
            repeat (2) tick();
            check($sformatf("parity_c%0d", c), y_par, ey);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
